fdam_rd_unpacker: RTL and testbench
===================================

// Module: fdam_rd_unpacker
// PURPOSE
//  Read-side stream stage between the FDAM read channel and the CGRA input queue.
//  Issues line read requests, buffers returned lines, and unpacks each line into
//  LINE_W/WORD_W words on a valid/ready stream.
//  Signals completion once FDAM reports end-of-read and every buffered word is consumed.
// PARAMETERS
//  LINE_W      512  width of one FDAM read line
//  WORD_W      32   width of one output word; LINE_W % WORD_W == 0
//  FIFO_DEPTH  4    line buffer depth; power of two, >= 2
// PORTS
//  clk                       in   1       clock; all logic on rising edge
//  rst                       in   1       synchronous reset, active-low (0 = reset)
//  start                     in   1       level; run enable, sampled in IDLE
//  acc_user_done_rd_data     in   1       FDAM: no further read lines will be granted
//  acc_user_available_read   in   1       FDAM: a read request may be issued this cycle
//  acc_user_request_read     out  1       one-cycle pulse per requested line
//  acc_user_read_data_valid  in   1       returned line valid this cycle
//  acc_user_read_data        in   LINE_W  returned line
//  word_valid                out  1       output word valid
//  word_data                 out  WORD_W  output word
//  word_ready                in   1       consumer accepts word
//  rd_done                   out  1       all data delivered; sticky
//  rd_err                    out  1       sticky: line returned with no request outstanding
// BEHAVIOUR
//  Reset (rst==0 at posedge): all outputs 0, FSM=IDLE, FIFO empty, counters 0, word index 0.
//    Reset mid-operation discards in-flight lines and words.
//  FSM: IDLE -(start)-> RUN -(done_rd_data)-> DRAIN -(outstanding==0 && FIFO empty)-> DONE.
//    DONE holds until reset. start is ignored outside IDLE.
//  Credits: outstanding (requests issued, line not returned) + occupancy <= FIFO_DEPTH.
//    Counters are $clog2(FIFO_DEPTH)+1 bits wide.
//  acc_user_request_read = 1 for one cycle when all hold:
//    FSM==RUN, available_read==1, done_rd_data==0, outstanding+occupancy < FIFO_DEPTH.
//    The pulse is registered; outstanding increments in the same edge.
//    Back-to-back pulses are allowed while credits remain.
//  Read return: read_data_valid pushes read_data into the FIFO and decrements outstanding.
//    The push is accepted in any FSM state except IDLE/DONE.
//    A push with outstanding==0 is dropped and sets rd_err.
//  Unpack:
//    word_valid = FIFO non-empty.
//    word_data = head[idx*WORD_W +: WORD_W]; idx = 0 is bits [WORD_W-1:0] (LSW first).
//    On word_valid && word_ready: idx++. At idx == LINE_W/WORD_W-1 the head pops and idx wraps to 0.
//    word_data/word_valid must stay stable while word_valid && !word_ready.
//  Latency: line pushed at edge t presents word 0 with word_valid=1 after edge t (cycle t+1).
//  Simultaneous push and pop: occupancy unchanged; a full FIFO may push if it pops that cycle.
//    The credit rule already prevents overflow.
//  Simultaneous request and return: outstanding unchanged.
//  done_rd_data in RUN with requests outstanding: stop requesting; DRAIN waits for returns.
//  rd_done=1 registered on entry to DONE (the cycle after the last word handshake
//    or last empty-state condition).
//  A zero-line transfer (done_rd_data while outstanding==0 and FIFO empty):
//    IDLE->RUN->DRAIN->DONE, rd_done after 3 edges from start.
// TESTING
//  1 line, available_read=1 always, ready=1 -> one request pulse;
//    16 words 0..15 in LSW-first order on consecutive cycles; rd_done 1 cycle after word 15.
//  FIFO_DEPTH=4, 8 lines, ready=0 -> exactly 4 request pulses, then request stays 0.
//    Raising ready resumes requests as lines pop; all 128 words in order.
//  ready toggled pseudo-randomly -> word_data stable while stalled; no word lost or duplicated.
//  done_rd_data raised with 2 requests outstanding -> no further requests;
//    rd_done only after both lines fully consumed.
//  read_data_valid with no request outstanding -> rd_err=1 sticky; FIFO occupancy unchanged.
//  rst=0 mid-line (idx=7) -> next cycle all outputs 0.
//    After start, the stream restarts cleanly at word 0 of a new line.

Source files
------------

// File: rtl/fdam_rd_unpacker_if.sv
// FDAM read channel plus the unpacked word stream.
// master is the unpacker side; slave is the FDAM/consumer side.
interface fdam_rd_unpacker_if #(
    parameter int LINE_W = 512,
    parameter int WORD_W = 32
);
    logic              acc_user_done_rd_data;
    logic              acc_user_available_read;
    logic              acc_user_request_read;
    logic              acc_user_read_data_valid;
    logic [LINE_W-1:0] acc_user_read_data;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;

    modport master (
        input  acc_user_done_rd_data,
        input  acc_user_available_read,
        output acc_user_request_read,
        input  acc_user_read_data_valid,
        input  acc_user_read_data,
        output word_valid,
        output word_data,
        input  word_ready
    );

    modport slave (
        output acc_user_done_rd_data,
        output acc_user_available_read,
        input  acc_user_request_read,
        output acc_user_read_data_valid,
        output acc_user_read_data,
        input  word_valid,
        input  word_data,
        output word_ready
    );
endinterface

// File: rtl/fdam_rd_unpacker.sv
// Credit-limited FDAM line reader with a small line FIFO,
// unpacking each buffered line LSW-first onto a word stream.
module fdam_rd_unpacker #(
    parameter int LINE_W     = 512,
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    fdam_rd_unpacker_if.master  bus,
    output logic                rd_done,
    output logic                rd_err
);
    localparam int NW = LINE_W / WORD_W;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [LINE_W-1:0]          mem [FIFO_DEPTH];
    logic [NW-1:0][WORD_W-1:0]  head;
    logic [CW-1:0]              outst, occ;
    logic [CW:0]                credit_used;
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic [IW-1:0]              idx;
    logic                       req_q, req_go;
    logic                       active, empty;
    logic                       ret, push, hs, pop, last_word;

    assign empty       = (occ == '0);
    assign active      = (state == RUN) || (state == DRAIN);
    assign credit_used = {1'b0, outst} + {1'b0, occ};

    assign req_go = (state == RUN)
                 && bus.acc_user_available_read
                 && !bus.acc_user_done_rd_data
                 && (credit_used < DEPTH_C);

    assign ret       = active && bus.acc_user_read_data_valid;
    assign push      = ret && (outst != '0);
    assign hs        = !empty && bus.word_ready;
    assign last_word = (idx == IW'(NW - 1));
    assign pop       = hs && last_word;

    assign head                      = mem[rd_ptr];
    assign bus.word_valid            = !empty;
    assign bus.word_data             = empty ? '0 : head[idx];
    assign bus.acc_user_request_read = req_q;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = RUN;
            RUN:   if (bus.acc_user_done_rd_data) state_nx = DRAIN;
            DRAIN: if (outst == '0 && empty) state_nx = DONE;
            DONE:  state_nx = DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Credits cover both in-flight and buffered lines, so a push never overflows.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_q   <= 1'b0;
            outst   <= '0;
            occ     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            idx     <= '0;
            rd_done <= 1'b0;
            rd_err  <= 1'b0;
        end else begin
            req_q <= req_go;
            outst <= outst + CW'(req_go) - CW'(push);
            occ   <= occ + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (hs)   idx <= last_word ? '0 : idx + 1'b1;
            if (state_nx == DONE) rd_done <= 1'b1;
            if (ret && outst == '0) rd_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.acc_user_read_data;
    end
endmodule

// File: tb/tb_fdam_rd_unpacker.sv
// Directed bench for fdam_rd_unpacker: scenario table plus
// hand-written zero-line, error and mid-line reset sequences.
module tb_fdam_rd_unpacker;
    logic clk;
    logic rst;
    logic start;
    logic rd_done;
    logic rd_err;

    int n_cmp = 0;
    int n_bad = 0;

    fdam_rd_unpacker_if #(.LINE_W(512), .WORD_W(32)) bus ();

    fdam_rd_unpacker #(
        .LINE_W(512),
        .WORD_W(32),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bus(bus),
        .rd_done(rd_done),
        .rd_err(rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode: 0 ready=1, 1 ready=0 for 60 cycles, 2 random, 3 alternating
    typedef struct {
        int          n_lines;
        int          mode;
        int          lat;
        int          exp_req;
        int          exp_words;
        int          exp_stall;
        int          exp_gap;
        logic [31:0] base;
    } scn_t;

    scn_t tbl [5];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] make_line(
        input logic [31:0] base, input int k);
        logic [511:0] l;
        for (int w = 0; w < 16; w++)
            l[w*32 +: 32] = base + 32'(k * 16 + w);
        return l;
    endfunction

    task automatic chk_quiet(input string nm);
        chk({nm, "_req"},   32'(bus.acc_user_request_read), 0);
        chk({nm, "_valid"}, 32'(bus.word_valid), 0);
        chk({nm, "_data"},  bus.word_data, 0);
        chk({nm, "_done"},  32'(rd_done), 0);
        chk({nm, "_err"},   32'(rd_err), 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        bus.acc_user_done_rd_data    = 1'b0;
        bus.acc_user_available_read  = 1'b0;
        bus.acc_user_read_data_valid = 1'b0;
        bus.acc_user_read_data       = '0;
        bus.word_ready               = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_quiet("reset");
        rst = 1'b1;
    endtask

    task automatic run_scn(input scn_t s, input int abort);
        int          q[$];
        int          req_cnt = 0;
        int          ret_k = 0;
        int          exp = 0;
        int          last_hs = -1;
        int          stall_reqs = -1;
        int          first_ret = -1;
        int          first_vld = -1;
        int          done_cyc = -1;
        bit          prev_stall = 0;
        logic [31:0] prev_data = '0;
        do_reset();
        bus.acc_user_available_read = 1'b1;
        start = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (rd_done) begin
                done_cyc = cyc;
                break;
            end
            if (bus.acc_user_request_read) begin
                req_cnt++;
                q.push_back(cyc + s.lat);
                if (req_cnt == s.n_lines)
                    bus.acc_user_done_rd_data = 1'b1;
            end
            if (bus.word_valid && first_vld < 0) first_vld = cyc;
            if (prev_stall) begin
                chk("stall_valid", 32'(bus.word_valid), 1);
                chk("stall_data", bus.word_data, prev_data);
            end
            case (s.mode)
                0: bus.word_ready = 1'b1;
                1: bus.word_ready = (cyc >= 60);
                2: bus.word_ready = 1'($urandom_range(0, 1));
                default: bus.word_ready = 1'(cyc & 1);
            endcase
            if (s.mode == 1 && cyc == 60) stall_reqs = req_cnt;
            if (bus.word_valid && bus.word_ready) begin
                chk("word", bus.word_data, s.base + 32'(exp));
                exp++;
                last_hs = cyc;
                if (abort >= 0 && exp == abort) return;
            end
            prev_stall = bus.word_valid && !bus.word_ready;
            prev_data  = bus.word_data;
            if (q.size() > 0 && q[0] == cyc) begin
                void'(q.pop_front());
                if (first_ret < 0) first_ret = cyc;
                bus.acc_user_read_data_valid = 1'b1;
                bus.acc_user_read_data = make_line(s.base, ret_k);
                ret_k++;
            end else begin
                bus.acc_user_read_data_valid = 1'b0;
            end
        end
        chk("rd_done_seen", 32'(done_cyc >= 0), 1);
        chk("n_req", req_cnt, s.exp_req);
        chk("n_words", exp, s.exp_words);
        chk("rd_err_clear", 32'(rd_err), 0);
        chk("latency", first_vld - first_ret, 1);
        if (done_cyc >= 0) begin
            chk("done_gap", done_cyc - last_hs, s.exp_gap);
            chk("idle_valid", 32'(bus.word_valid), 0);
        end
        if (s.exp_stall >= 0)
            chk("stall_reqs", stall_reqs, s.exp_stall);
    endtask

    initial begin
        scn_t s;
        rst = 1'b0;
        start = 1'b0;
        tbl[0] = '{1, 0, 2, 1, 16,  -1, 2, 32'h0000};
        tbl[1] = '{8, 1, 2, 8, 128,  4, 2, 32'h1000};
        tbl[2] = '{5, 2, 3, 5, 80,  -1, 2, 32'h2000};
        tbl[3] = '{2, 0, 6, 2, 32,  -1, 2, 32'h3000};
        tbl[4] = '{3, 3, 1, 3, 48,  -1, 2, 32'h4000};

        for (int i = 0; i < 5; i++)
            run_scn(tbl[i], -1);

        // zero-line transfer: done already high when started
        do_reset();
        bus.acc_user_done_rd_data   = 1'b1;
        bus.acc_user_available_read = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zl_done_e1", 32'(rd_done), 0);
        chk("zl_req_e1", 32'(bus.acc_user_request_read), 0);
        @(negedge clk);
        chk("zl_done_e2", 32'(rd_done), 0);
        chk("zl_req_e2", 32'(bus.acc_user_request_read), 0);
        @(negedge clk);
        chk("zl_done_e3", 32'(rd_done), 1);

        // unsolicited return line
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.acc_user_read_data_valid = 1'b1;
        bus.acc_user_read_data = make_line(32'h7000, 0);
        @(negedge clk);
        bus.acc_user_read_data_valid = 1'b0;
        chk("err_set", 32'(rd_err), 1);
        chk("err_valid", 32'(bus.word_valid), 0);
        repeat (3) @(negedge clk);
        chk("err_sticky", 32'(rd_err), 1);
        chk("err_valid2", 32'(bus.word_valid), 0);

        // reset while the head line sits at word 7
        run_scn(tbl[0], 7);
        @(negedge clk);
        rst = 1'b0;
        bus.word_ready = 1'b0;
        bus.acc_user_read_data_valid = 1'b0;
        @(negedge clk);
        chk_quiet("midrst");
        s = tbl[0];
        s.base = 32'h5000;
        run_scn(s, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
